// File: rtl/mont_final_reduce.sv
// -----------------------------------------------------------------------------
// mont_final_reduce
//
// Final reduction stage behind the Montgomery multiplier top. A rising edge on
// done_in captures the raw sum S_in and the modulus M. The block then reduces
// the captured sum modulo M by repeated conditional subtraction, one decision
// per clock, and presents the result on a valid/ready handshake.
//
// Handshake: res/err are offered while res_valid = 1. They are held stable
// until the consumer drives res_ready = 1 at a clock edge where res_valid = 1.
// The transfer happens on that edge. res_ready has no effect at any other
// time.
//
// Ports
//   clk        in   1    system clock, rising edge
//   rst        in   1    synchronous active-high reset
//   S_in       in   SW   raw Montgomery sum
//   done_in    in   1    multiplier done level; its rising edge starts a capture
//   M          in   MW   modulus, sampled on the capture edge
//   res        out  MW   reduced result, meaningful while res_valid = 1
//   res_valid  out  1    result available
//   res_ready  in   1    consumer accepts res
//   busy       out  1    block is in REDUCE or OUT
//   err        out  1    result is invalid: M == 0 or subtraction budget exhausted
//   drop       out  1    one-cycle pulse: a done_in rising edge arrived while busy
//   dbg_state  out  2    current FSM state (0 IDLE, 1 REDUCE, 2 OUT)
// -----------------------------------------------------------------------------
module mont_final_reduce #(
    parameter int SW      = 9,
    parameter int MW      = 6,
    parameter int MAX_SUB = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [SW-1:0] S_in,
    input  logic          done_in,
    input  logic [MW-1:0] M,
    output logic [MW-1:0] res,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          busy,
    output logic          err,
    output logic          drop,
    output logic [1:0]    dbg_state
);

    // Wide enough to hold the value MAX_SUB itself.
    localparam int CW = $clog2(MAX_SUB + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_SUB);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        OUT    = 2'd2
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_acc;
    logic [MW-1:0]   r_m_q;
    logic [CW-1:0]   r_cnt;
    logic [MW-1:0]   r_res;
    logic            r_res_valid;
    logic            r_err;
    logic            r_drop;
    logic            r_done_d;

    logic            w_rise;
    logic [SW-1:0]   w_m_ext;
    logic            w_ge;
    logic            w_m_zero;
    logic            w_budget_left;

    // r_done_d resets to 1 so a done_in level that is still high when reset
    // releases is not mistaken for a fresh edge.
    assign w_rise        = done_in & ~r_done_d;

    // Compare and subtract at the accumulator width; since the subtraction
    // only happens when acc >= m_q, acc can never wrap.
    assign w_m_ext       = {{(SW-MW){1'b0}}, r_m_q};
    assign w_ge          = (r_acc >= w_m_ext);
    assign w_m_zero      = (r_m_q == '0);
    assign w_budget_left = (r_cnt < MAX_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_m_q       <= '0;
            r_cnt       <= '0;
            r_res       <= '0;
            r_res_valid <= 1'b0;
            r_err       <= 1'b0;
            r_drop      <= 1'b0;
            r_done_d    <= 1'b1;
        end else begin
            r_done_d <= done_in;
            // Any edge seen outside IDLE is discarded; the operation in flight
            // continues untouched.
            r_drop   <= w_rise && (r_state != IDLE);

            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_acc   <= S_in;
                        r_m_q   <= M;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_state <= REDUCE;
                    end
                end

                REDUCE: begin
                    if (w_m_zero) begin
                        // Reduction by zero is meaningless; report it at once.
                        r_err       <= 1'b1;
                        r_res       <= '0;
                        r_res_valid <= 1'b1;
                        r_state     <= OUT;
                    end else if (w_ge && w_budget_left) begin
                        r_acc <= r_acc - w_m_ext;
                        r_cnt <= r_cnt + 1'b1;
                    end else if (w_ge) begin
                        // Budget spent but still not below m_q: emit the
                        // partially reduced low bits flagged as an error.
                        r_err       <= 1'b1;
                        r_res       <= r_acc[MW-1:0];
                        r_res_valid <= 1'b1;
                        r_state     <= OUT;
                    end else begin
                        r_res       <= r_acc[MW-1:0];
                        r_res_valid <= 1'b1;
                        r_state     <= OUT;
                    end
                end

                OUT: begin
                    // res and err keep their values after the transfer.
                    if (r_res_valid && res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_res_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign res       = r_res;
    assign res_valid = r_res_valid;
    assign err       = r_err;
    assign drop      = r_drop;
    assign busy      = (r_state != IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mont_final_reduce.sv
module tb_mont_final_reduce;

  localparam int SW = 9;
  localparam int MW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] s_in;
  logic          done_in;
  logic [MW-1:0] m_in;
  logic [MW-1:0] res;
  logic          res_valid;
  logic          res_ready;
  logic          busy;
  logic          err;
  logic          drop;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // expected results of completed operations: {err, res}
  logic [MW:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mont_final_reduce #(.SW(SW), .MW(MW), .MAX_SUB(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .S_in      (s_in),
    .done_in   (done_in),
    .M         (m_in),
    .res       (res),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .err       (err),
    .drop      (drop),
    .dbg_state (dbg_state)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  // advance one rising edge; inputs are driven and outputs sampled 1 ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Capture (s, m) on a clean done_in edge, expect res_valid exactly `lat`
  // edges after the capture edge, and compare against the expected queue.
  task automatic run_op(input logic [SW-1:0] s, input logic [MW-1:0] m,
                        input int lat, input logic [MW-1:0] e_res, input logic e_err,
                        input logic complete);
    logic [MW:0] e;
    exp_q.push_back({e_err, e_res});
    done_in = 1'b0;
    step();
    s_in = s;
    m_in = m;
    done_in = 1'b1;
    step();                      // capture edge
    check("busy_after_capture", 32'(busy), 32'd1);
    s_in = ~s;                   // inputs are free to change after capture
    m_in = ~m;
    for (int i = 1; i < lat; i++) begin
      step();
      check("valid_early", 32'(res_valid), 32'd0);
    end
    step();
    check("valid_at_latency", 32'(res_valid), 32'd1);
    e = exp_q.pop_front();
    check("res", 32'(res), 32'(e[MW-1:0]));
    check("err", 32'(err), 32'(e[MW]));
    if (complete) begin
      step();                    // handshake edge (res_ready is 1)
      check("valid_after_hs", 32'(res_valid), 32'd0);
      check("busy_after_hs", 32'(busy), 32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    done_in = 1'b1;
    s_in = '0;
    m_in = '0;
    res_ready = 1'b1;
    step();
    step();
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_res", 32'(res), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);

    // done_in still high after reset must not capture
    rst = 1'b0;
    s_in = 9'd42;
    m_in = 6'd13;
    step();
    step();
    check("no_capture_busy", 32'(busy), 32'd0);
    check("no_capture_valid", 32'(res_valid), 32'd0);

    // 42 mod 13: 3 subtractions -> valid 4 edges after capture, res 3
    run_op(9'd42, 6'd13, 4, 6'd3, 1'b0, 1'b1);

    // 5 < 13: valid 1 edge after capture, then held under back-pressure
    res_ready = 1'b0;
    run_op(9'd5, 6'd13, 1, 6'd5, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_res", 32'(res), 32'd5);
      check("hold_err", 32'(err), 32'd0);
    end
    res_ready = 1'b1;
    step();
    check("release_valid", 32'(res_valid), 32'd0);
    check("release_busy", 32'(busy), 32'd0);
    check("release_state", 32'(dbg_state), 32'd0);
    check("release_res_held", 32'(res), 32'd5);

    // M == 0: immediate error
    run_op(9'd200, 6'd0, 1, 6'd0, 1'b1, 1'b1);

    // 511 mod 3 needs 170 subtractions; budget of 8 -> 511-24=487, low bits 39
    run_op(9'd511, 6'd3, 9, 6'd39, 1'b1, 1'b1);

    // err clears on the next capture; 63 mod 7 = 0 after 9 subtractions? no:
    // 63 = 9*7 would need 9 > 8, so use 62 mod 7: 8 subtractions -> 6
    run_op(9'd62, 6'd7, 9, 6'd6, 1'b0, 1'b1);

    // exact multiple within budget: 52 = 4*13 -> res 0
    run_op(9'd52, 6'd13, 5, 6'd0, 1'b0, 1'b1);

    // second done_in rise during REDUCE is dropped
    done_in = 1'b0;
    step();
    s_in = 9'd42;
    m_in = 6'd13;
    done_in = 1'b1;
    step();                      // capture edge
    done_in = 1'b0;
    step();
    check("drop_idle", 32'(drop), 32'd0);
    done_in = 1'b1;
    step();                      // rise seen in REDUCE
    check("drop_pulse", 32'(drop), 32'd1);
    step();
    check("drop_one_cycle", 32'(drop), 32'd0);
    check("drop_valid_pending", 32'(res_valid), 32'd0);
    step();                      // 4 edges after capture
    check("drop_valid", 32'(res_valid), 32'd1);
    check("drop_res", 32'(res), 32'd3);
    check("drop_err", 32'(err), 32'd0);
    step();
    check("drop_hs_busy", 32'(busy), 32'd0);

    // reset during REDUCE aborts without a result
    done_in = 1'b0;
    step();
    s_in = 9'd511;
    m_in = 6'd3;
    done_in = 1'b1;
    step();
    step();
    step();
    check("pre_abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    check("abort_valid", 32'(res_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      check("abort_no_result", 32'(res_valid), 32'd0);
    end
    check("abort_still_idle", 32'(busy), 32'd0);

    // capture still works after the abort
    run_op(9'd20, 6'd13, 2, 6'd7, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // global time limit so a stuck run still terminates
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mont_final_reduce.md
Name: mont_final_reduce

Overview:
- Downstream stage of the Montgomery multiplier top. It consumes the 9-bit raw Montgomery sum S and the done level from the kernel chain, and reduces S modulo M by repeated conditional subtraction, so the result lies in [0, M).
- It presents the 6-bit reduced result on a valid/ready handshake to the next consumer.
- It detects an illegal modulus (M == 0) and runaway reduction, and flags both.

Parameters:
- SW, 9, width of incoming sum S_in.
- MW, 6, width of modulus M and result res.
- MAX_SUB, 8, maximum subtractions allowed per operand before err is raised.

Ports:
- clk, input, 1, system clock (rising edge).
- rst, input, 1, synchronous active-high reset.
- S_in, input, SW, raw Montgomery sum from the multiplier top.
- done_in, input, 1, multiplier done level; a capture is triggered on its rising edge.
- M, input, MW, modulus; sampled on the capture edge.
- res, output, MW, reduced result; valid while res_valid = 1.
- res_valid, output, 1, result available.
- res_ready, input, 1, consumer accepts res.
- busy, output, 1, high in REDUCE and OUT states.
- err, output, 1, error status of the current result (M == 0 or MAX_SUB exceeded); valid with res_valid.
- drop, output, 1, one-cycle pulse when a done_in rising edge is ignored because the block is not IDLE.

Behaviour:
- Reset (rst = 1 at a clk edge):
  - state <= IDLE; res, res_valid, err, drop, busy <= 0; acc, m_q, cnt <= 0.
  - done_d <= 1, so a done_in still high after reset does not capture; done_in must fall first.
  - Reset mid-REDUCE or mid-OUT aborts the operation with no result.
- Edge detect: rise = done_in & ~done_d; done_d <= done_in every non-reset cycle.
- States: IDLE, REDUCE, OUT. busy = (state != IDLE), combinational from state.
- IDLE:
  - On rise: acc <= S_in (SW bits), m_q <= M, cnt <= 0, err <= 0, state <= REDUCE.
  - Otherwise hold.
- REDUCE: one decision per clk edge, priority order:
  1. m_q == 0: err <= 1, res <= 0, res_valid <= 1, state <= OUT.
  2. acc >= {zero-extended m_q} and cnt < MAX_SUB: acc <= acc - m_q, cnt <= cnt + 1.
  3. acc >= m_q and cnt == MAX_SUB: err <= 1, res <= acc[MW-1:0], res_valid <= 1, state <= OUT.
  4. acc < m_q: res <= acc[MW-1:0], res_valid <= 1, state <= OUT.
- Arithmetic:
  - Compare and subtract at SW width with m_q zero-extended; acc never underflows.
  - cnt is ceil(log2(MAX_SUB+1)) bits wide.
- Latency: for k required subtractions, res_valid rises k+1 clk edges after the capture edge. For S_in < M, that is 1 edge.
- OUT:
  - res, err and res_valid are held stable until res_ready = 1 is sampled with res_valid = 1.
  - On that edge: res_valid <= 0, state <= IDLE; res and err hold their last values.
  - res_ready is ignored outside OUT.
- Simultaneous events:
  - A done_in rising edge during REDUCE or OUT is not captured: drop = 1 for exactly that cycle, and the operation in flight is unaffected.
  - A rising edge on the same cycle the OUT handshake completes is also dropped, because the state is not IDLE at that edge.
- Stability: S_in and M may change freely after the capture edge; only the latched acc and m_q are used.
- rst has priority over all other events.

Test Plan:
- Reset with done_in held 1, then rst released -> no capture, res_valid = 0, busy = 0. Drop done_in to 0 then 1 -> capture occurs.
- S_in = 42, M = 13, rise, res_ready = 1 -> res_valid rises 4 edges after capture edge; res = 3, err = 0; busy falls the edge after handshake.
- S_in = 5, M = 13 -> res_valid 1 edge after capture, res = 5. With res_ready = 0 for 10 cycles, res, err and res_valid stay stable; res_ready = 1 -> IDLE next edge.
- S_in = 200, M = 0 -> res_valid 1 edge after capture, err = 1, res = 0.
- S_in = 511, M = 3 (needs 170 subtractions) -> after MAX_SUB = 8 subtractions, err = 1, res = (511 - 24) mod 64 = 39, res_valid rises 9 edges after capture.
- Second done_in rise while in REDUCE -> drop pulses exactly 1 cycle, first result is unaffected. Assert rst during REDUCE -> res_valid = 0, state IDLE next edge, no result is emitted.
